ssd1963_rd: RTL and testbench



---
 rtl/ssd1963_rd_pkg.sv | 23 ++
 rtl/ssd1963_rd_fifo.sv | 58 +++++
 rtl/ssd1963_rd.sv | 192 +++++++++++++++++++
 tb/tb_ssd1963_rd.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd1963_rd_pkg.sv
// Shared definitions for the SSD1963 8080-style read engine:
// register map, STATUS bit positions and the bus sequencer states.
package ssd1963_rd_pkg;

  localparam logic [2:0] ADDR_CTL    = 3'd0;
  localparam logic [2:0] ADDR_CMD    = 3'd1;
  localparam logic [2:0] ADDR_COUNT  = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_DATA   = 3'd4;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_FULL  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_LO,
    ST_CMD_HI,
    ST_RD_LO,
    ST_RD_HI
  } state_t;

endpackage

// File: rtl/ssd1963_rd_fifo.sv
// Single-clock show-ahead byte FIFO: head always presents the oldest entry.
// Pushes while full and pops while empty are dropped.
module ssd1963_rd_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    head,
  output logic          empty,
  output logic          full,
  output logic [LW-1:0] level
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  // Storage has no reset; only the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ssd1963_rd.sv
// SSD1963 read engine: one command write followed by COUNT RD strobes,
// captured bytes queued in a FIFO that software drains via the DATA register.
module ssd1963_rd
  import ssd1963_rd_pkg::*;
#(
  parameter int WR_LOW_CYC  = 2,
  parameter int WR_HIGH_CYC = 2,
  parameter int RD_LOW_CYC  = 4,
  parameter int RD_HIGH_CYC = 2,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  avalon_slave_address,
  input  logic        avalon_slave_chipselect,
  input  logic        avalon_slave_write,
  input  logic        avalon_slave_read,
  input  logic [31:0] avalon_slave_writedata,
  output logic [31:0] avalon_slave_readdata,
  output logic        disp_cs_n,
  output logic        disp_dc_n,
  output logic        disp_wr_n,
  output logic        disp_rd_n,
  output logic [7:0]  disp_d_out,
  output logic        disp_d_oe,
  input  logic [7:0]  disp_d_in
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [7:0] WR_LO_LOAD = 8'(WR_LOW_CYC - 1);
  localparam logic [7:0] WR_HI_LOAD = 8'(WR_HIGH_CYC - 1);
  localparam logic [7:0] RD_LO_LOAD = 8'(RD_LOW_CYC - 1);
  localparam logic [7:0] RD_HI_LOAD = 8'(RD_HIGH_CYC - 1);

  state_t        state, state_nxt;
  logic [7:0]    cnt, cnt_nxt;
  logic [15:0]   remaining, rem_nxt;
  logic [7:0]    cmd_work, cmd_work_nxt;
  logic [7:0]    cmd_reg;
  logic [15:0]   count_reg;
  logic          start, push, pop, busy;
  logic          fifo_empty, fifo_full;
  logic [7:0]    fifo_head;
  logic [LW-1:0] fifo_level;
  logic          unused_bits;

  assign unused_bits = ^avalon_slave_writedata[31:16];

  assign start = avalon_slave_chipselect && avalon_slave_write &&
                 (avalon_slave_address == ADDR_CTL) && avalon_slave_writedata[0];
  assign pop   = avalon_slave_chipselect && avalon_slave_read &&
                 (avalon_slave_address == ADDR_DATA) && !fifo_empty;
  assign busy  = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmd_reg   <= '0;
      count_reg <= '0;
    end else if (avalon_slave_chipselect && avalon_slave_write) begin
      case (avalon_slave_address)
        ADDR_CMD:   cmd_reg   <= avalon_slave_writedata[7:0];
        ADDR_COUNT: count_reg <= avalon_slave_writedata[15:0];
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      remaining <= '0;
      cmd_work  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      remaining <= rem_nxt;
      cmd_work  <= cmd_work_nxt;
    end
  end

  // Each phase loads its length minus one and advances when the counter
  // reaches zero; a full FIFO simply parks the counter at zero.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = (cnt != 8'd0) ? cnt - 8'd1 : cnt;
    rem_nxt      = remaining;
    cmd_work_nxt = cmd_work;
    push         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt    = ST_CMD_LO;
          cnt_nxt      = WR_LO_LOAD;
          rem_nxt      = count_reg;
          cmd_work_nxt = cmd_reg;
        end
      end
      ST_CMD_LO: begin
        if (cnt == 8'd0) begin
          state_nxt = ST_CMD_HI;
          cnt_nxt   = WR_HI_LOAD;
        end
      end
      ST_CMD_HI, ST_RD_HI: begin
        if (cnt == 8'd0) begin
          if (remaining == 16'd0) begin
            state_nxt = ST_IDLE;
          end else if (!fifo_full) begin
            state_nxt = ST_RD_LO;
            cnt_nxt   = RD_LO_LOAD;
          end
        end
      end
      ST_RD_LO: begin
        if (cnt == 8'd0) begin
          push      = 1'b1;
          rem_nxt   = (remaining != 16'd0) ? remaining - 16'd1 : remaining;
          state_nxt = ST_RD_HI;
          cnt_nxt   = RD_HI_LOAD;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    disp_cs_n  = 1'b1;
    disp_dc_n  = 1'b1;
    disp_wr_n  = 1'b1;
    disp_rd_n  = 1'b1;
    disp_d_out = 8'h00;
    disp_d_oe  = 1'b0;
    case (state)
      ST_CMD_LO: begin
        disp_cs_n  = 1'b0;
        disp_dc_n  = 1'b0;
        disp_wr_n  = 1'b0;
        disp_d_out = cmd_work;
        disp_d_oe  = 1'b1;
      end
      ST_CMD_HI: begin
        disp_cs_n  = 1'b0;
        disp_dc_n  = 1'b0;
        disp_d_out = cmd_work;
        disp_d_oe  = 1'b1;
      end
      ST_RD_LO: begin
        disp_cs_n = 1'b0;
        disp_rd_n = 1'b0;
      end
      ST_RD_HI: begin
        disp_cs_n = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    avalon_slave_readdata = 32'h0;
    case (avalon_slave_address)
      ADDR_CMD:    avalon_slave_readdata = {24'h0, cmd_reg};
      ADDR_COUNT:  avalon_slave_readdata = {16'h0, count_reg};
      ADDR_STATUS: begin
        avalon_slave_readdata[15:8]       = 8'(fifo_level);
        avalon_slave_readdata[STAT_BUSY]  = busy;
        avalon_slave_readdata[STAT_EMPTY] = fifo_empty;
        avalon_slave_readdata[STAT_FULL]  = fifo_full;
      end
      ADDR_DATA:   avalon_slave_readdata = fifo_empty ? 32'h0 : {24'h0, fifo_head};
      default:     ;
    endcase
  end

  ssd1963_rd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (disp_d_in),
    .pop     (pop),
    .head    (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (fifo_level)
  );

endmodule

// File: tb/tb_ssd1963_rd.sv
// Directed self-checking bench for ssd1963_rd: a negedge bus monitor plays the
// panel (supplies read bytes) and tallies strobe shapes for the scenario tasks.
module tb_ssd1963_rd;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic        disp_cs_n, disp_dc_n, disp_wr_n, disp_rd_n, disp_d_oe;
  logic [7:0]  disp_d_out;
  logic [7:0]  disp_d_in = 8'h00;

  int checks = 0;
  int errors = 0;

  logic [7:0] cmd_exp = 8'h00;
  logic [7:0] seq_base = 8'h00;
  int         pulse_mark = 0;

  int wr_pulses = 0, wr_len_bad = 0, wr_bad = 0, wr_run = 0;
  int rd_pulses = 0, rd_len_bad = 0, rd_run = 0, rd_dc_bad = 0;
  int gap = 0, gap_bad = 0, contention = 0, saw55 = 0;
  logic gap_active = 1'b0;
  logic prev_wr = 1'b1, prev_rd = 1'b1;

  ssd1963_rd dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .avalon_slave_address    (address),
    .avalon_slave_chipselect (chipselect),
    .avalon_slave_write      (write),
    .avalon_slave_read       (read),
    .avalon_slave_writedata  (writedata),
    .avalon_slave_readdata   (readdata),
    .disp_cs_n               (disp_cs_n),
    .disp_dc_n               (disp_dc_n),
    .disp_wr_n               (disp_wr_n),
    .disp_rd_n               (disp_rd_n),
    .disp_d_out              (disp_d_out),
    .disp_d_oe               (disp_d_oe),
    .disp_d_in               (disp_d_in)
  );

  always #5 clk = ~clk;

  // Panel model: a new byte appears on each RD falling edge, in sequence.
  always @(negedge clk) begin
    if (!disp_wr_n) begin
      if (prev_wr) begin
        wr_pulses++;
        wr_run = 1;
      end else begin
        wr_run++;
      end
      if (disp_dc_n !== 1'b0 || disp_d_out !== cmd_exp || disp_d_oe !== 1'b1) wr_bad++;
    end else if (!prev_wr) begin
      if (wr_run != 2) wr_len_bad++;
    end
    if (!disp_rd_n) begin
      if (prev_rd) begin
        if (gap_active && gap != 2) gap_bad++;
        disp_d_in = seq_base + 8'(rd_pulses - pulse_mark);
        rd_pulses++;
        rd_run = 1;
      end else begin
        rd_run++;
      end
      if (disp_dc_n !== 1'b1 || disp_cs_n !== 1'b0) rd_dc_bad++;
      if (disp_d_oe !== 1'b0) contention++;
    end else begin
      if (!prev_rd) begin
        if (rd_run != 4) rd_len_bad++;
        gap = 1;
        gap_active = 1'b1;
      end else begin
        gap++;
      end
    end
    if (disp_cs_n) gap_active = 1'b0;
    if (disp_d_oe === 1'b1 && disp_d_out === 8'h55) saw55++;
    prev_wr = disp_wr_n;
    prev_rd = disp_rd_n;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog");
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0; writedata = 32'h0;
  endtask

  task automatic peek(input logic [2:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    #1;
    d = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic pop_byte(output logic [31:0] d);
    @(posedge clk); #1;
    chipselect = 1'b1; read = 1'b1; address = 3'd4;
    #1;
    d = readdata;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    logic [31:0] s;
    int n;
    n = 0;
    s = 32'h1;
    while (s[0] && n < budget) begin
      @(posedge clk); #1;
      peek(3'd3, s);
      n++;
    end
    checks++;
    if (s[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_idle: busy=%b after %0d cycles, expected 0", name, s[0], n);
    end
  endtask

  task automatic test_reset();
    logic [31:0] s;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({disp_cs_n, disp_dc_n, disp_wr_n, disp_rd_n} !== 4'b1111) begin
      errors++; $display("[TB] FAIL reset_strobes: got %b, expected 1111", {disp_cs_n, disp_dc_n, disp_wr_n, disp_rd_n}); end
    checks++; if (disp_d_oe !== 1'b0 || disp_d_out !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_bus: oe=%b d_out=%h, expected 0/00", disp_d_oe, disp_d_out); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    peek(3'd3, s);
    checks++; if (s !== 32'h0000_0002) begin
      errors++; $display("[TB] FAIL reset_status: got %h, expected 00000002", s); end
    peek(3'd1, s);
    checks++; if (s !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_cmd: got %h, expected 0", s); end
    peek(3'd4, s);
    checks++; if (s !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_data: got %h, expected 0", s); end
  endtask

  task automatic test_cmd_only();
    logic [31:0] s;
    int wp, wl, wb, rp;
    cmd_exp = 8'h01;
    wp = wr_pulses; wl = wr_len_bad; wb = wr_bad; rp = rd_pulses;
    bus_write(3'd1, 32'h01);
    bus_write(3'd2, 32'h0);
    peek(3'd1, s);
    checks++; if (s !== 32'h01) begin
      errors++; $display("[TB] FAIL cmd_readback: got %h, expected 01", s); end
    bus_write(3'd0, 32'h1);
    peek(3'd3, s);
    checks++; if (s[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL cmd_only_busy: got %b, expected 1", s[0]); end
    wait_idle(50, "cmd_only");
    repeat (2) @(posedge clk); #1;
    checks++; if (wr_pulses - wp != 1) begin
      errors++; $display("[TB] FAIL cmd_only_wr_pulses: got %0d, expected 1", wr_pulses - wp); end
    checks++; if (wr_len_bad - wl != 0 || wr_bad - wb != 0) begin
      errors++; $display("[TB] FAIL cmd_only_wr_shape: len_bad=%0d field_bad=%0d, expected 0/0", wr_len_bad - wl, wr_bad - wb); end
    checks++; if (rd_pulses - rp != 0) begin
      errors++; $display("[TB] FAIL cmd_only_rd_pulses: got %0d, expected 0", rd_pulses - rp); end
    peek(3'd3, s);
    checks++; if (s !== 32'h0000_0002 || disp_cs_n !== 1'b1) begin
      errors++; $display("[TB] FAIL cmd_only_end: status=%h cs_n=%b, expected 00000002/1", s, disp_cs_n); end
  endtask

  task automatic test_reads();
    logic [31:0] s, d;
    int wp, wb, rp, rl, gb, ct, rdb;
    cmd_exp = 8'hA1; seq_base = 8'h11; pulse_mark = rd_pulses;
    wp = wr_pulses; wb = wr_bad; rp = rd_pulses; rl = rd_len_bad;
    gb = gap_bad; ct = contention; rdb = rd_dc_bad;
    bus_write(3'd1, 32'hA1);
    bus_write(3'd2, 32'd5);
    bus_write(3'd0, 32'h1);
    wait_idle(200, "reads");
    repeat (2) @(posedge clk); #1;
    checks++; if (wr_pulses - wp != 1 || wr_bad - wb != 0) begin
      errors++; $display("[TB] FAIL reads_cmd: pulses=%0d bad=%0d, expected 1/0", wr_pulses - wp, wr_bad - wb); end
    checks++; if (rd_pulses - rp != 5) begin
      errors++; $display("[TB] FAIL reads_count: got %0d, expected 5", rd_pulses - rp); end
    checks++; if (rd_len_bad - rl != 0 || gap_bad - gb != 0) begin
      errors++; $display("[TB] FAIL reads_timing: low_bad=%0d gap_bad=%0d, expected 0/0", rd_len_bad - rl, gap_bad - gb); end
    checks++; if (contention - ct != 0 || rd_dc_bad - rdb != 0) begin
      errors++; $display("[TB] FAIL reads_bus: contention=%0d dc_bad=%0d, expected 0/0", contention - ct, rd_dc_bad - rdb); end
    peek(3'd3, s);
    checks++; if (s !== 32'h0000_0500) begin
      errors++; $display("[TB] FAIL reads_level: status=%h, expected 00000500", s); end
    for (int i = 0; i < 5; i++) begin
      pop_byte(d);
      checks++; if (d !== 32'h11 + 32'(i)) begin
        errors++; $display("[TB] FAIL reads_data%0d: got %h, expected %h", i, d, 32'h11 + 32'(i)); end
    end
    pop_byte(d);
    checks++; if (d !== 32'h0) begin
      errors++; $display("[TB] FAIL reads_data_empty: got %h, expected 0", d); end
    peek(3'd3, s);
    checks++; if (s !== 32'h0000_0002) begin
      errors++; $display("[TB] FAIL reads_drained: status=%h, expected 00000002", s); end
  endtask

  task automatic test_backpressure();
    logic [31:0] s, d;
    int rp, n;
    cmd_exp = 8'h22; seq_base = 8'h40; pulse_mark = rd_pulses;
    rp = rd_pulses;
    bus_write(3'd1, 32'h22);
    bus_write(3'd2, 32'd20);
    bus_write(3'd0, 32'h1);
    n = 0;
    while (rd_pulses - rp < 16 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (20) @(posedge clk); #1;
    checks++; if (rd_pulses - rp != 16) begin
      errors++; $display("[TB] FAIL bp_stall_count: got %0d reads, expected 16", rd_pulses - rp); end
    peek(3'd3, s);
    checks++; if (s !== 32'h0000_1005) begin
      errors++; $display("[TB] FAIL bp_stall_status: got %h, expected 00001005", s); end
    checks++; if (disp_cs_n !== 1'b0 || disp_rd_n !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_stall_bus: cs_n=%b rd_n=%b, expected 0/1", disp_cs_n, disp_rd_n); end
    for (int i = 0; i < 4; i++) begin
      pop_byte(d);
      checks++; if (d !== 32'h40 + 32'(i)) begin
        errors++; $display("[TB] FAIL bp_pop%0d: got %h, expected %h", i, d, 32'h40 + 32'(i)); end
    end
    wait_idle(200, "bp");
    checks++; if (rd_pulses - rp != 20) begin
      errors++; $display("[TB] FAIL bp_total: got %0d reads, expected 20", rd_pulses - rp); end
    peek(3'd3, s);
    checks++; if (s !== 32'h0000_1004) begin
      errors++; $display("[TB] FAIL bp_end_status: got %h, expected 00001004", s); end
    for (int i = 4; i < 20; i++) begin
      pop_byte(d);
      checks++; if (d !== 32'h40 + 32'(i)) begin
        errors++; $display("[TB] FAIL bp_drain%0d: got %h, expected %h", i, d, 32'h40 + 32'(i)); end
    end
  endtask

  task automatic test_start_busy();
    logic [31:0] s, d;
    int wp, rp, s55;
    cmd_exp = 8'h33; seq_base = 8'h60; pulse_mark = rd_pulses;
    wp = wr_pulses; rp = rd_pulses; s55 = saw55;
    bus_write(3'd1, 32'h33);
    bus_write(3'd2, 32'd3);
    bus_write(3'd0, 32'h1);
    repeat (6) @(posedge clk);
    bus_write(3'd1, 32'h55);
    bus_write(3'd0, 32'h1);
    wait_idle(200, "start_busy");
    repeat (4) @(posedge clk); #1;
    checks++; if (saw55 - s55 != 0) begin
      errors++; $display("[TB] FAIL busy_no55: bus showed 55 for %0d cycles, expected 0", saw55 - s55); end
    checks++; if (wr_pulses - wp != 1 || rd_pulses - rp != 3) begin
      errors++; $display("[TB] FAIL busy_counts: wr=%0d rd=%0d, expected 1/3", wr_pulses - wp, rd_pulses - rp); end
    peek(3'd3, s);
    checks++; if (s !== 32'h0000_0300) begin
      errors++; $display("[TB] FAIL busy_status: got %h, expected 00000300", s); end
    for (int i = 0; i < 3; i++) begin
      pop_byte(d);
      checks++; if (d !== 32'h60 + 32'(i)) begin
        errors++; $display("[TB] FAIL busy_data%0d: got %h, expected %h", i, d, 32'h60 + 32'(i)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] s, d;
    int n, rl, rp;
    cmd_exp = 8'h44; seq_base = 8'h70; pulse_mark = rd_pulses;
    bus_write(3'd1, 32'h44);
    bus_write(3'd2, 32'd4);
    bus_write(3'd0, 32'h1);
    n = 0;
    while (disp_rd_n !== 1'b0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (disp_rd_n !== 1'b0) begin
      errors++; $display("[TB] FAIL rmid_reach_rd: rd_n=%b after %0d cycles, expected 0", disp_rd_n, n); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (disp_rd_n !== 1'b1 || disp_cs_n !== 1'b1 || disp_d_oe !== 1'b0) begin
      errors++; $display("[TB] FAIL rmid_bus: rd_n=%b cs_n=%b oe=%b, expected 1/1/0", disp_rd_n, disp_cs_n, disp_d_oe); end
    peek(3'd3, s);
    checks++; if (s !== 32'h0000_0002) begin
      errors++; $display("[TB] FAIL rmid_status: got %h, expected 00000002", s); end
    reset_n = 1'b1;
    cmd_exp = 8'h45;
    bus_write(3'd1, 32'h45);
    bus_write(3'd2, 32'd2);
    seq_base = 8'h80; pulse_mark = rd_pulses;
    rl = rd_len_bad; rp = rd_pulses;
    bus_write(3'd0, 32'h1);
    wait_idle(200, "rmid_fresh");
    repeat (2) @(posedge clk); #1;
    checks++; if (rd_pulses - rp != 2 || rd_len_bad - rl != 0) begin
      errors++; $display("[TB] FAIL rmid_fresh_reads: count=%0d low_bad=%0d, expected 2/0", rd_pulses - rp, rd_len_bad - rl); end
    for (int i = 0; i < 2; i++) begin
      pop_byte(d);
      checks++; if (d !== 32'h80 + 32'(i)) begin
        errors++; $display("[TB] FAIL rmid_data%0d: got %h, expected %h", i, d, 32'h80 + 32'(i)); end
    end
  endtask

  initial begin
    test_reset();
    test_cmd_only();
    test_reads();
    test_backpressure();
    test_start_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
